// File: rtl/ram_pkg.sv
// Shared widths, defaults and FSM state type for the latency-modelled RAM.
package ram_pkg;
  localparam int WORD_W      = 32;
  localparam int DEF_DEPTH_W = 10;
  localparam int DEF_LATENCY = 4;
  localparam int CNT_W       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/ram_delay.sv
// Latency countdown: loads a start value, decrements on request, flags zero.
module ram_delay
  import ram_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);
  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
endmodule

// File: rtl/ram.sv
// Single-port RAM; any change of {data,addr,wr} starts an access that completes LATENCY cycles later.
// o_response low while busy; a new input change aborts and restarts. RAM_STATS_EN adds access counters.
module ram
  import ram_pkg::*;
#(
  parameter int DEPTH_W = DEF_DEPTH_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [WORD_W-1:0] i_data,
  input  logic [WORD_W-1:0] i_addr,
  input  logic              i_wr,
  output logic              o_response,
  output logic [WORD_W-1:0] o_out
`ifdef RAM_STATS_EN
  ,
  output logic [31:0]       o_rd_count,
  output logic [31:0]       o_wr_count
`endif
);
  state_t            r_state;
  logic [WORD_W-1:0] r_data;
  logic [WORD_W-1:0] r_addr;
  logic              r_wr;
  logic              r_response;
  logic [WORD_W-1:0] r_out;
  logic [WORD_W-1:0] r_mem [0:(1<<DEPTH_W)-1] = '{default: '0};

  logic              w_chg;
  logic              w_busy;
  logic              w_done;
  logic              w_dec;
  logic              w_zero;
  logic [CNT_W-1:0]  w_cnt;
  logic [DEPTH_W-1:0] w_idx;

  // Full 32-bit address takes part in detection even though only the low bits index memory.
  assign w_chg  = (i_data != r_data) || (i_addr != r_addr) || (i_wr != r_wr);
  assign w_busy = (r_state == BUSY);
  assign w_done = w_busy && !w_chg && w_zero;
  assign w_dec  = w_busy && !w_chg && (w_cnt != '0);
  assign w_idx  = r_addr[DEPTH_W-1:0];

  ram_delay #(.W(CNT_W)) u_delay (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_chg),
    .i_load_val (CNT_W'(LATENCY - 1)),
    .i_dec      (w_dec),
    .o_count    (w_cnt),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_response <= 1'b1;
      r_out      <= '0;
    end else if (w_chg) begin
      r_data     <= i_data;
      r_addr     <= i_addr;
      r_wr       <= i_wr;
      r_response <= 1'b0;
      r_state    <= BUSY;
    end else if (w_done) begin
      r_state    <= IDLE;
      r_response <= 1'b1;
      if (!r_wr) begin
        r_out <= r_mem[w_idx];
      end
    end
  end

  // Storage has no reset so contents survive rst_n; w_done is already low while in reset.
  always_ff @(posedge i_clk) begin
    if (w_done && r_wr) begin
      r_mem[w_idx] <= r_data;
    end
  end

  assign o_response = r_response;
  assign o_out      = r_out;

`ifdef RAM_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_done) begin
      if (r_wr) r_wr_count <= r_wr_count + 32'd1;
      else      r_rd_count <= r_rd_count + 32'd1;
    end
  end

  assign o_rd_count = r_rd_count;
  assign o_wr_count = r_wr_count;
`endif
endmodule

// File: tb/tb_ram.sv
// Randomised plus directed bench for ram against a request-age reference model.
module tb_ram;
  localparam int DW  = 10;
  localparam int LAT = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data  = '0;
  logic [31:0] addr  = '0;
  logic        wr    = 1'b0;
  logic        response;
  logic [31:0] out;
`ifdef RAM_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  always #5 clk = ~clk;

  ram #(.DEPTH_W(DW), .LATENCY(LAT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (data),
    .i_addr     (addr),
    .i_wr       (wr),
    .o_response (response),
    .o_out      (out)
`ifdef RAM_STATS_EN
    ,
    .o_rd_count (rd_count),
    .o_wr_count (wr_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is the latest distinct input tuple; it completes once it has aged LAT edges.
  logic [31:0] m_mem [0:(1<<DW)-1];
  logic [64:0] m_prev = '0;
  logic [64:0] m_req  = '0;
  bit          m_pend = 1'b0;
  int          m_age  = 0;
  logic [31:0] m_out  = '0;
  logic [31:0] m_rd   = '0;
  logic [31:0] m_wr   = '0;
  bit          cmp_en = 1'b0;

  function automatic int widx(input logic [31:0] a);
    return int'(a % 32'(1 << DW));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = '0;
      m_pend = 1'b0;
      m_age  = 0;
      m_out  = '0;
      m_rd   = '0;
      m_wr   = '0;
    end else if ({data, addr, wr} != m_prev) begin
      m_prev = {data, addr, wr};
      m_req  = {data, addr, wr};
      m_pend = 1'b1;
      m_age  = 0;
    end else if (m_pend) begin
      m_age++;
      if (m_age == LAT) begin
        m_pend = 1'b0;
        if (m_req[0]) begin
          m_mem[widx(m_req[32:1])] = m_req[64:33];
          m_wr++;
        end else begin
          m_out = m_mem[widx(m_req[32:1])];
          m_rd++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("response", 32'(response), 32'(!m_pend));
      chk("out", out, m_out);
`ifdef RAM_STATS_EN
      chk("rd_count", rd_count, m_rd);
      chk("wr_count", wr_count, m_wr);
`endif
    end
  end

  task automatic expect_busy(input string name);
    repeat (LAT) begin
      @(negedge clk);
      chk(name, 32'(response), 32'd0);
    end
    @(negedge clk);
    chk({name, "_done"}, 32'(response), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    data = '0;
    addr = a;
    wr   = 1'b0;
    expect_busy({name, "_busy"});
    chk(name, out, exp);
  endtask

  initial begin
    for (int i = 0; i < (1 << DW); i++) m_mem[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_resp", 32'(response), 32'd1);
    chk("rst_out", out, 32'd0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_resp", 32'(response), 32'd1);
      chk("idle_out", out, 32'd0);
    end

    data = 32'hDEADBEEF; addr = 32'd5; wr = 1'b1;
    expect_busy("wr5");
    chk("wr5_out", out, 32'd0);

    wr = 1'b0;
    expect_busy("rd5");
    chk("rd5_out", out, 32'hDEADBEEF);

    data = 32'h12345678; addr = 32'd3; wr = 1'b1;
    repeat (2) @(negedge clk);
    addr = 32'd7;
    expect_busy("wr7");
    chk("wr7_out", out, 32'hDEADBEEF);
    do_read(32'd3, 32'd0, "rd3_aborted");
    do_read(32'd7, 32'h12345678, "rd7");
    do_read(32'h405, 32'hDEADBEEF, "rd405_alias");

    data = 32'hA5A5A5A5; addr = 32'd9; wr = 1'b1;
    expect_busy("wr9");
    data = 32'h11111111;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_imm_resp", 32'(response), 32'd1);
    chk("rst_imm_out", out, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_read(32'd9, 32'hA5A5A5A5, "rd9_after_rst");

    repeat (300) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        wr = ~wr;
      end else if (sel == 1) begin
        data = $urandom;
      end else begin
        logic [31:0] a;
        a = 32'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 3)) << DW);
        data = $urandom;
        addr = a;
        wr   = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 30) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      repeat ($urandom_range(1, LAT + 3)) @(negedge clk);
    end

    repeat (LAT + 2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
